// File: rtl/pid_controller_multi.sv
// pid_controller_multi: time-multiplexed PID controller serving NUM_CH channels through one shared datapath
module pid_controller_multi #(
    parameter int NUM_CH = 4,
    parameter int FB_W   = 32,
    parameter int GAIN_W = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_ch,
    input  logic [3:0]              cfg_addr,
    input  logic [FB_W-1:0]         cfg_data,
    input  logic [NUM_CH*FB_W-1:0]  feedback,
    input  logic                    update_controller,
    output logic [NUM_CH*OUT_W-1:0] pwm_ref,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);
    localparam int ACC_W = FB_W + GAIN_W + 2;
    localparam int SUM_W = ACC_W + 2;
    typedef struct packed {
        logic signed [GAIN_W-1:0] kp, ki, kd, db, opos, oneg, ipos, ineg;
        logic                     mode;
    } cfg_t;
    typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, WRITE, DONE} state_t;
    cfg_t                    cfg [NUM_CH];
    logic signed [FB_W-1:0]  sp_r [NUM_CH];
    logic signed [ACC_W-1:0] integ [NUM_CH];
    logic signed [FB_W-1:0]  last_err [NUM_CH];
    state_t                  state, state_nx;
    logic [3:0]              ch;
    logic                    upd_cur, upd_prev, rise, in_db;
    cfg_t                    cfg_sel, cs;
    logic signed [FB_W-1:0]  sp_sel, fb_sel, last_sel, err;
    logic signed [FB_W:0]    err_abs;
    logic signed [ACC_W-1:0] integ_sel, p, d, i_inc, i_hi, i_lo, integ_acc, integ_nx;
    logic signed [ACC_W:0]   i_sum;
    logic signed [SUM_W-1:0] sum, y_full, o_hi, o_lo;
    logic signed [OUT_W-1:0] y;

    function automatic logic signed [FB_W-1:0] sat(input logic signed [FB_W:0] v);
        return (v[FB_W] != v[FB_W-1]) ? {v[FB_W], {(FB_W-1){~v[FB_W]}}} : v[FB_W-1:0];
    endfunction

    always_comb begin
        rise     = upd_cur && !upd_prev;
        busy     = state != IDLE;
        done     = state == DONE;
        overrun  = rise && busy;
        state_nx = state;
        case (state)
            IDLE:    state_nx = rise ? LOAD : IDLE;
            LOAD:    state_nx = MUL;
            MUL:     state_nx = ACC;
            ACC:     state_nx = WRITE;
            WRITE:   state_nx = (ch == 4'(NUM_CH - 1)) ? DONE : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cfg_sel   = '0;
        sp_sel    = '0;
        fb_sel    = '0;
        last_sel  = '0;
        integ_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 4'(i)) begin
                cfg_sel   = cfg[i];
                sp_sel    = sp_r[i];
                fb_sel    = feedback[i*FB_W +: FB_W];
                last_sel  = last_err[i];
                integ_sel = integ[i];
            end
        end
        err_abs   = err[FB_W-1] ? -((FB_W+1)'(err)) : (FB_W+1)'(err);
        in_db     = !cs.db[GAIN_W-1] && cs.db != '0 && err_abs < (FB_W+1)'($signed(cs.db));
        i_hi      = ACC_W'($signed(cs.ipos)) <<< SHIFT;
        i_lo      = ACC_W'($signed(cs.ineg)) <<< SHIFT;
        i_sum     = (ACC_W+1)'(integ_sel) + (ACC_W+1)'(i_inc);
        integ_acc = in_db ? integ_sel :
                    i_sum > (ACC_W+1)'(i_hi) ? i_hi :
                    i_sum < (ACC_W+1)'(i_lo) ? i_lo : ACC_W'(i_sum);
        y_full    = sum >>> SHIFT;
        o_hi      = SUM_W'($signed(cs.opos));
        o_lo      = SUM_W'($signed(cs.oneg));
        y         = OUT_W'((o_lo > o_hi || y_full > o_hi) ? o_hi : y_full < o_lo ? o_lo : y_full);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cfg[i]  <= '0;
                sp_r[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_ch == 4'(i)) begin
                    case (cfg_addr)
                        4'd0:    cfg[i].kp   <= cfg_data[GAIN_W-1:0];
                        4'd1:    cfg[i].ki   <= cfg_data[GAIN_W-1:0];
                        4'd2:    cfg[i].kd   <= cfg_data[GAIN_W-1:0];
                        4'd3:    sp_r[i]     <= cfg_data;
                        4'd4:    cfg[i].db   <= cfg_data[GAIN_W-1:0];
                        4'd5:    cfg[i].opos <= cfg_data[GAIN_W-1:0];
                        4'd6:    cfg[i].oneg <= cfg_data[GAIN_W-1:0];
                        4'd7:    cfg[i].ipos <= cfg_data[GAIN_W-1:0];
                        4'd8:    cfg[i].ineg <= cfg_data[GAIN_W-1:0];
                        4'd9:    cfg[i].mode <= cfg_data[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            upd_cur  <= 1'b0;
            upd_prev <= 1'b0;
            ch       <= '0;
            cs       <= '0;
            err      <= '0;
            p        <= '0;
            d        <= '0;
            i_inc    <= '0;
            integ_nx <= '0;
            sum      <= '0;
            pwm_ref  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                integ[i]    <= '0;
                last_err[i] <= '0;
            end
        end else begin
            upd_cur  <= update_controller;
            upd_prev <= upd_cur;
            if (state == LOAD) begin
                cs  <= cfg_sel;
                err <= sat((FB_W+1)'(sp_sel) - (FB_W+1)'(fb_sel));
            end
            if (state == MUL) begin
                p     <= ACC_W'($signed(cs.kp)) * ACC_W'(err);
                d     <= ACC_W'($signed(cs.kd)) * ACC_W'(sat((FB_W+1)'(err) - (FB_W+1)'(last_sel)));
                i_inc <= ACC_W'($signed(cs.ki)) * ACC_W'(err);
            end
            if (state == ACC) begin
                integ_nx <= integ_acc;
                sum      <= in_db ? SUM_W'(integ_acc) : SUM_W'(p) + SUM_W'(d) + SUM_W'(integ_acc);
            end
            if (state == WRITE) begin
                ch <= (ch == 4'(NUM_CH - 1)) ? '0 : ch + 4'd1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch == 4'(i)) begin
                        pwm_ref[i*OUT_W +: OUT_W] <= cs.mode ? y : '0;
                        integ[i]                  <= cs.mode ? integ_nx : '0;
                        last_err[i]               <= cs.mode ? err : '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pid_controller_multi.sv
// tb_pid_controller_multi: table, hand-sequence and randomized checks against a per-channel PID reference model
module tb_pid_controller_multi;
    localparam int N = 4, FB_W = 32, GAIN_W = 16, OUT_W = 16, SHIFT = 8, KMAX = 4 * N + 6;
    localparam longint FMAX = (longint'(1) <<< (FB_W - 1)) - 1;
    localparam longint FMIN = -(longint'(1) <<< (FB_W - 1));

    typedef struct {
        longint fb;
        longint db;
        longint exp;
    } vec_t;

    logic               clock = 1'b0, reset_n = 1'b0, cfg_we = 1'b0, update_controller = 1'b0;
    logic [3:0]         cfg_ch = '0, cfg_addr = '0;
    logic [FB_W-1:0]    cfg_data = '0;
    logic [N*FB_W-1:0]  feedback = '0;
    logic [N*OUT_W-1:0] pwm_ref;
    logic               busy, done, overrun;

    pid_controller_multi #(.NUM_CH(N), .FB_W(FB_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .feedback(feedback), .update_controller(update_controller),
        .pwm_ref(pwm_ref), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int     n_cmp = 0, n_fail = 0, sweep_id = 0;
    longint m_cfg [N][10];
    longint m_integ [N], m_last [N], m_out [N], m_fb [N];
    int     done_cnt, done_first, ovr_cnt, ovr_first;
    logic   busy_k [KMAX];
    logic [N*OUT_W-1:0] snap [KMAX];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        return (v << (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction

    function automatic longint pwm_of(input int c);
        return sx(longint'(pwm_ref[c*OUT_W +: OUT_W]), OUT_W);
    endfunction

    function automatic longint snap_val(input int k, input int c);
        return sx(longint'(snap[k][c*OUT_W +: OUT_W]), OUT_W);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            for (int a = 0; a < 10; a++) m_cfg[c][a] = 0;
            m_integ[c] = 0;
            m_last[c]  = 0;
            m_out[c]   = 0;
        end
    endtask

    task automatic cfg_model(input int c, input int a, input longint dv);
        if (c < N && a <= 9)
            m_cfg[c][a] = (a == 3) ? sx(dv, FB_W) : (a == 9) ? (dv & 1) : sx(dv, GAIN_W);
    endtask

    // One full sweep of the PID law, channel by channel, in plain integer arithmetic
    task automatic model_sweep();
        longint e, de, s, y;
        for (int c = 0; c < N; c++) begin
            if (m_cfg[c][9] == 0) begin
                m_out[c] = 0; m_integ[c] = 0; m_last[c] = 0;
                continue;
            end
            e  = clamp(m_cfg[c][3] - m_fb[c], FMIN, FMAX);
            de = clamp(e - m_last[c], FMIN, FMAX);
            if (m_cfg[c][4] > 0 && (e < 0 ? -e : e) < m_cfg[c][4]) s = m_integ[c];
            else begin
                m_integ[c] = clamp(m_integ[c] + m_cfg[c][1] * e,
                                   m_cfg[c][8] * (longint'(1) << SHIFT), m_cfg[c][7] * (longint'(1) << SHIFT));
                s = m_cfg[c][0] * e + m_cfg[c][2] * de + m_integ[c];
            end
            y = s >>> SHIFT;
            m_out[c]  = (m_cfg[c][6] > m_cfg[c][5]) ? m_cfg[c][5] : clamp(y, m_cfg[c][6], m_cfg[c][5]);
            m_last[c] = e;
        end
    endtask

    task automatic wr(input int c, input int a, input longint dv);
        @(negedge clock);
        cfg_we = 1'b1; cfg_ch = 4'(c); cfg_addr = 4'(a); cfg_data = FB_W'(dv);
        @(negedge clock);
        cfg_we = 1'b0;
        cfg_model(c, a, dv);
    endtask

    // Sample k is taken on the falling edge inside cycle t+k, where t is the cycle the rising edge is seen
    task automatic sweep(input logic [15:0] pat, input int wk, input int wc, input int wa, input longint wd,
                         input int exp_ovr);
        @(negedge clock);
        for (int c = 0; c < N; c++) feedback[c*FB_W +: FB_W] = FB_W'(m_fb[c]);
        update_controller = 1'b1;
        done_cnt = 0; done_first = -1; ovr_cnt = 0; ovr_first = -1;
        for (int k = 0; k < KMAX; k++) begin
            @(negedge clock);
            busy_k[k] = busy;
            snap[k]   = pwm_ref;
            if (done) begin done_cnt++; if (done_first < 0) done_first = k; end
            if (overrun) begin ovr_cnt++; if (ovr_first < 0) ovr_first = k; end
            update_controller = (k < 16) ? pat[k] : 1'b0;
            cfg_we = (k == wk);
            if (k == wk) begin cfg_ch = 4'(wc); cfg_addr = 4'(wa); cfg_data = FB_W'(wd); end
        end
        cfg_we = 1'b0;
        if (wk >= 0 && wk <= 4 * wc) cfg_model(wc, wa, wd);
        model_sweep();
        if (wk >= 0 && wk > 4 * wc) cfg_model(wc, wa, wd);
        chk($sformatf("s%0d_done_cnt", sweep_id), done_cnt, 1);
        chk($sformatf("s%0d_done_at", sweep_id), done_first, 4 * N + 1);
        chk($sformatf("s%0d_ovr_cnt", sweep_id), ovr_cnt, exp_ovr);
        chk($sformatf("s%0d_busy_t0", sweep_id), longint'(busy_k[0]), 0);
        chk($sformatf("s%0d_busy_t1", sweep_id), longint'(busy_k[1]), 1);
        chk($sformatf("s%0d_busy_last", sweep_id), longint'(busy_k[4 * N + 1]), 1);
        chk($sformatf("s%0d_busy_after", sweep_id), longint'(busy_k[4 * N + 2]), 0);
        for (int c = 0; c < N; c++) chk($sformatf("s%0d_pwm_ch%0d", sweep_id, c), pwm_of(c), m_out[c]);
        sweep_id++;
    endtask

    function automatic longint rnd_gain();
        return ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 65535)) : longint'($urandom_range(0, 600)) - 300;
    endfunction

    initial begin
        vec_t   tbl [11];
        longint a0, a1;
        tbl = '{'{0, 0, 100}, '{0, 0, 200}, '{0, 0, 250}, '{0, 0, 250}, '{200, 0, 150}, '{70, 50, 150},
                '{150, 50, 100}, '{130, 50, 100}, '{50, 0, 150}, '{600, 0, -300}, '{100, -5, -300}};
        model_reset();
        for (int c = 0; c < N; c++) m_fb[c] = 0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_overrun", longint'(overrun), 0);
        for (int c = 0; c < N; c++) chk($sformatf("rst_pwm_ch%0d", c), pwm_of(c), 0);
        sweep(16'h0, -1, 0, 0, 0, 0);

        wr(1, 0, 4); wr(1, 3, 1000); wr(1, 5, 32767); wr(1, 6, -32767); wr(1, 9, 1);
        sweep(16'h0, -1, 0, 0, 0, 0);
        chk("p_only_ch1_t9", snap_val(9, 1), 15);
        chk("p_only_ch0", pwm_of(0), 0);
        chk("p_only_ch2", pwm_of(2), 0);

        wr(0, 1, 256); wr(0, 3, 100); wr(0, 5, 1000); wr(0, 6, -1000);
        wr(0, 7, 250); wr(0, 8, -300); wr(0, 9, 1);
        for (int i = 0; i < 11; i++) begin
            m_fb[0] = tbl[i].fb;
            wr(0, 4, tbl[i].db);
            sweep(16'h0, -1, 0, 0, 0, 0);
            chk($sformatf("tbl%0d_ch0", i), pwm_of(0), tbl[i].exp);
        end

        sweep(16'h0004, -1, 0, 0, 0, 1);
        chk("overrun_at", ovr_first, 3);

        sweep(16'h0, 4, 1, 0, 8, 0);
        chk("cfg_before_load", pwm_of(1), 31);
        sweep(16'h0, 5, 1, 0, 4, 0);
        chk("cfg_at_load", pwm_of(1), 31);
        sweep(16'h0, -1, 0, 0, 0, 0);
        chk("cfg_next_sweep", pwm_of(1), 15);

        wr(2, 0, 1); wr(2, 3, FMAX); wr(2, 5, 32767); wr(2, 6, -32767); wr(2, 9, 1);
        m_fb[2] = FMIN;
        wr(3, 0, 1); wr(3, 5, 5); wr(3, 6, 10); wr(3, 9, 1);
        m_fb[3] = 2560;
        sweep(16'h0, -1, 0, 0, 0, 0);
        chk("err_saturate_ch2", pwm_of(2), 32767);
        chk("inverted_limits_ch3", pwm_of(3), 5);
        wr(3, 6, -100);
        m_fb[3] = 2561;
        sweep(16'h0, -1, 0, 0, 0, 0);
        chk("floor_neg_ch3", pwm_of(3), -11);

        wr(1, 10, 99); wr(4, 0, 99);
        sweep(16'h0, -1, 0, 0, 0, 0);

        @(negedge clock);
        update_controller = 1'b1;
        @(negedge clock);
        update_controller = 1'b0;
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", longint'(busy), 0);
        for (int c = 0; c < N; c++) chk($sformatf("midrst_pwm_ch%0d", c), pwm_of(c), 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        wr(1, 0, 4); wr(1, 3, 1000); wr(1, 5, 32767); wr(1, 6, -32767); wr(1, 9, 1);
        m_fb[1] = 0;
        sweep(16'h0, -1, 0, 0, 0, 0);
        chk("midrst_resweep_ch1_t9", snap_val(9, 1), 15);

        for (int it = 0; it < 30; it++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 1) == 0) begin
                    wr(c, 0, rnd_gain()); wr(c, 1, rnd_gain()); wr(c, 2, rnd_gain());
                    wr(c, 3, ($urandom_range(0, 4) == 0) ? longint'($urandom) : longint'($urandom_range(0, 20000)) - 10000);
                    wr(c, 4, longint'($urandom_range(0, 300)) - 50);
                    wr(c, 5, longint'($urandom_range(0, 6000)) - 3000);
                    wr(c, 6, longint'($urandom_range(0, 6000)) - 3000);
                    a0 = longint'($urandom_range(0, 4000)) - 2000;
                    a1 = longint'($urandom_range(0, 4000)) - 2000;
                    wr(c, 7, a0 > a1 ? a0 : a1);
                    wr(c, 8, a0 > a1 ? a1 : a0);
                    wr(c, 9, longint'($urandom_range(0, 3) != 0));
                end
                case ($urandom_range(0, 2))
                    0:       m_fb[c] = sx(m_cfg[c][3] + longint'($urandom_range(0, 400)) - 200, FB_W);
                    1:       m_fb[c] = longint'($urandom_range(0, 20000)) - 10000;
                    default: m_fb[c] = sx(longint'($urandom), FB_W);
                endcase
            end
            sweep(16'h0, -1, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
